wallace_seq8x8_ctrl: RTL and testbench
======================================

WALLACE_SEQ8X8_CTRL -- requirements
Module: wallace_seq8x8_ctrl

Interface
REQ-001 Parameters: none; all widths are fixed (8x8 operands, 16-bit product).
REQ-002 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start_valid  input  1  requester presents operands a, b.
REQ-006 start_ready  output  1  block can accept operands; high only in IDLE and only while rst is low.
REQ-007 a  input  8  unsigned multiplicand, sampled on accept.
REQ-008 b  input  8  unsigned multiplier, sampled on accept.
REQ-009 res_valid  output  1  product is valid.
REQ-010 res_ready  input  1  consumer takes product.
REQ-011 product  output  16  registered unsigned result a*b.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 Datapath: exactly one instance of the team's combinational 4x4 Wallace multiplier (wallace_Multiplier: a, b, pro); no other multiplier logic.
REQ-014 Accept: start_valid && start_ready at a clock edge latches a and b, clears acc[15:0] to 0, and moves to MUL with step=0.
REQ-015 FSM states: IDLE, MUL, DONE; no other states are reachable.
REQ-016 MUL step 0: feed a[3:0] and b[3:0] to the multiplier; add pro<<0 to acc.
REQ-017 MUL step 1: feed a[7:4] and b[3:0]; add pro<<4 to acc.
REQ-018 MUL step 2: feed a[3:0] and b[7:4]; add pro<<4 to acc.
REQ-019 MUL step 3: feed a[7:4] and b[7:4]; add pro<<8 to acc; go to DONE.
REQ-020 Each MUL step takes one clock.
REQ-021 Acc is 16 bits; no overflow is possible, and no carry beyond bit 15 is kept.
REQ-022 Latency: res_valid rises exactly 4 clocks after the accept edge.
REQ-023 product = acc; product is stable while res_valid is high.
REQ-024 DONE: res_valid=1; it holds indefinitely while res_ready=0.
REQ-025 res_valid && res_ready at an edge moves to IDLE, deasserts res_valid, and keeps product unchanged.
REQ-026 No overlap: start_valid outside IDLE is ignored, and operand changes outside the accept edge have no effect.
REQ-027 A new accept is possible on the clock after the res handshake; start_ready is 0 in the handshake cycle itself.
REQ-028 The multiplier inputs are don't-care in IDLE and DONE but shall not be X in simulation; drive them to 0.

Reset
REQ-029 rst high at an edge: state=IDLE, step=0, acc=0, product=0, res_valid=0, busy=0.
REQ-030 start_ready=0 while rst is high.
REQ-031 rst has priority over every handshake.
REQ-032 rst mid-operation (MUL or DONE) aborts the operation silently; no res_valid is produced for the aborted operands.
REQ-033 The first accept is possible on the first edge after rst deasserts.

Configuration
REQ-034 Macro WALLACE_ZERO_SKIP_EN, when defined: on accept with a==0 or b==0, go directly to DONE with acc=0; res_valid rises 1 clock after accept, and no MUL steps are taken.
REQ-035 WALLACE_ZERO_SKIP_EN undefined: zero operands take the full 4 MUL steps with latency 4; the result is identical.

Verification
REQ-036 Reset then a=0xFF, b=0xFF, res_ready=1 -> res_valid 4 clocks after accept, product=0xFE01, then IDLE.
REQ-037 a=0x12, b=0x34, res_ready held 0 for 3 clocks after res_valid -> product=0x03A8 stable with res_valid high; handshake on the 4th clock; start_ready=1 on the next clock.
REQ-038 start_valid held high with a=0x0F, b=0x0F during MUL of 0x12*0x34 -> ignored, result 0x03A8; 0x0F*0x0F=0x00E1 accepted only after return to IDLE.
REQ-039 a=0x00, b=0xAB -> product=0x0000 after 1 clock with WALLACE_ZERO_SKIP_EN, after 4 clocks without it.
REQ-040 rst pulsed during MUL step 2 of 0x80*0x80 -> res_valid never rises, product=0, start_ready=1 the clock after rst falls; a following 0x80*0x80 gives 0x4000.
REQ-041 Exhaustive sweep of all 256x256 operand pairs with random res_ready backpressure -> every product equals a*b, with exactly one res_valid per accept.

Source files
------------

// File: rtl/wallace_seq8x8_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one 4x4 Wallace tree; optional WALLACE_ZERO_SKIP_EN.
// Latency: res_valid 4 clocks after accept (1 clock for zero operands when WALLACE_ZERO_SKIP_EN is set).
// Backpressure: one operation in flight; result held in DONE until res_ready, start_ready low meanwhile.

// 4x4 unsigned Wallace-tree multiplier.
// Latency: combinational.
// Backpressure: none.
module wallace_Multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] pro
);
    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    logic [3:0][3:0] p;
    logic s1, c1, s2, c2, s3a, c3a, s4a, c4a, s5a, c5a;
    logic u2, v2, u3, v3, u4, v4, u5, v5, u6, v6;
    logic [7:0] row_x, row_y;

    always_comb begin
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                p[i][j] = a[i] & b[j];
    end

    // first layer: compress columns 1..5 of the partial-product matrix
    assign s1  = p[1][0] ^ p[0][1];
    assign c1  = p[1][0] & p[0][1];
    assign s2  = p[2][0] ^ p[1][1] ^ p[0][2];
    assign c2  = maj(p[2][0], p[1][1], p[0][2]);
    assign s3a = p[3][0] ^ p[2][1] ^ p[1][2];
    assign c3a = maj(p[3][0], p[2][1], p[1][2]);
    assign s4a = p[3][1] ^ p[2][2] ^ p[1][3];
    assign c4a = maj(p[3][1], p[2][2], p[1][3]);
    assign s5a = p[3][2] ^ p[2][3];
    assign c5a = p[3][2] & p[2][3];

    // second layer leaves at most two bits per column for the final adder
    assign u2 = s2 ^ c1;
    assign v2 = s2 & c1;
    assign u3 = s3a ^ p[0][3] ^ c2;
    assign v3 = maj(s3a, p[0][3], c2);
    assign u4 = s4a ^ c3a;
    assign v4 = s4a & c3a;
    assign u5 = s5a ^ c4a;
    assign v5 = s5a & c4a;
    assign u6 = p[3][3] ^ c5a;
    assign v6 = p[3][3] & c5a;

    assign row_x = {v6, u6, u5, u4, u3, u2, s1, p[0][0]};
    assign row_y = {1'b0, v5, v4, v3, v2, 3'b000};
    assign pro   = row_x + row_y;
endmodule

// 8x8 multiply controller: four 4x4 partial products accumulated over four MUL cycles.
// Latency: 4 clocks accept-to-res_valid (1 clock on zero operands with WALLACE_ZERO_SKIP_EN).
// Backpressure: res_valid held with stable product until res_ready; no new accept until IDLE.
module wallace_seq8x8_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  op_a, op_b;
    logic [15:0] acc, partial, acc_next;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_pro;

    wallace_Multiplier u_mul (
        .a   (mul_a),
        .b   (mul_b),
        .pro (mul_pro)
    );

    assign start_ready = (state == IDLE) && !rst;

    // multiplier inputs are forced to zero outside MUL so they never float to X
    always_comb begin
        mul_a   = 4'h0;
        mul_b   = 4'h0;
        partial = 16'h0000;
        if (state == MUL) begin
            case (step)
                2'd0: begin mul_a = op_a[3:0]; mul_b = op_b[3:0]; partial = {8'h00, mul_pro};      end
                2'd1: begin mul_a = op_a[7:4]; mul_b = op_b[3:0]; partial = {8'h00, mul_pro} << 4; end
                2'd2: begin mul_a = op_a[3:0]; mul_b = op_b[7:4]; partial = {8'h00, mul_pro} << 4; end
                default: begin mul_a = op_a[7:4]; mul_b = op_b[7:4]; partial = {8'h00, mul_pro} << 8; end
            endcase
        end
        acc_next = acc + partial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            acc       <= 16'h0000;
            product   <= 16'h0000;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            op_a      <= 8'h00;
            op_b      <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        op_a <= a;
                        op_b <= b;
                        acc  <= 16'h0000;
                        step <= 2'd0;
                        busy <= 1'b1;
`ifdef WALLACE_ZERO_SKIP_EN
                        if (a == 8'h00 || b == 8'h00) begin
                            state   <= DONE;
                            product <= 16'h0000;
                        end else begin
                            state <= MUL;
                        end
`else
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state     <= DONE;
                        product   <= acc_next;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_valid && res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
`ifdef WALLACE_ZERO_SKIP_EN
                    // zero-skip enters DONE straight from accept; raise res_valid one clock later
                    else if (!res_valid) begin
                        res_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wallace_seq8x8_ctrl.sv
// Directed bench for wallace_seq8x8_ctrl: latency, backpressure, overlap, reset abort, operand sweep.
module tb_wallace_seq8x8_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;
    int n_take = 0;
    int n_hs   = 0;

`ifdef WALLACE_ZERO_SKIP_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 4;
`endif

    wallace_seq8x8_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && res_valid && res_ready) n_hs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic accept(input logic [7:0] av, input logic [7:0] bv);
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_rdy", start_ready, 1);
        start_valid = 1'b1;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    // counts clocks from the accept edge until res_valid is seen
    task automatic wait_result(input int exp_lat, input string tag);
        int lat = 0;
        logic got = 1'b0;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) check({tag, "_busy"}, busy, 1);
            got = res_valid;
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic take(input int hold, input logic [15:0] exp, input string tag);
        res_ready = 1'b0;
        check({tag, "_prod"}, product, exp);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_vld"}, res_valid, 1);
            check({tag, "_hold_prod"}, product, exp);
        end
        res_ready = 1'b1;
        check({tag, "_hs_rdy"}, start_ready, 0);
        @(negedge clk);
        res_ready = 1'b0;
        n_take++;
        check({tag, "_post_vld"}, res_valid, 0);
        check({tag, "_post_prod"}, product, exp);
        check({tag, "_post_rdy"}, start_ready, 1);
    endtask

    initial begin
        logic [7:0]  vals [12];
        logic [7:0]  av, bv;
        logic [15:0] e;
        int          seen;

        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h0F, 8'h10, 8'h55, 8'h7F, 8'h80, 8'hAA, 8'hFF};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_prod", product, 16'h0000);
        check("rst_rdy", start_ready, 0);

        // first accept on the first edge after reset release
        rst = 1'b0;
        start_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        #1;
        check("rel_rdy", start_ready, 1);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        wait_result(4, "ffxff");
        take(0, 16'hFE01, "ffxff");

        // backpressure: res_ready low for 3 clocks
        accept(8'h12, 8'h34);
        wait_result(4, "bp");
        take(3, 16'h03A8, "bp");

        // start_valid held high through the operation is ignored until IDLE
        accept(8'h12, 8'h34);
        start_valid = 1'b1;
        a = 8'h0F;
        b = 8'h0F;
        wait_result(4, "ovl");
        take(0, 16'h03A8, "ovl");
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        wait_result(4, "ovl2");
        take(0, 16'h00E1, "ovl2");

        // zero operand
        accept(8'h00, 8'hAB);
        wait_result(ZLAT, "zero");
        take(1, 16'h0000, "zero");

        // reset aborts during MUL step 2
        accept(8'h33, 8'h03);
        wait_result(4, "pre");
        take(0, 16'h0099, "pre");
        accept(8'h80, 8'h80);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_rdy_in_rst", start_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_vld", res_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_prod", product, 16'h0000);
        check("abort_rdy", start_ready, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("abort_no_vld", seen, 0);
        accept(8'h80, 8'h80);
        wait_result(4, "x80");
        take(0, 16'h4000, "x80");

        // grid of corner operands with random backpressure
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 12; j++) begin
                av = vals[i];
                bv = vals[j];
                e  = {8'h00, av} * {8'h00, bv};
                accept(av, bv);
                wait_result((av == 8'h00 || bv == 8'h00) ? ZLAT : 4, "grid");
                take($urandom_range(0, 2), e, "grid");
            end
        end

        // random operand pairs
        for (int k = 0; k < 150; k++) begin
            av = 8'($urandom_range(0, 255));
            bv = 8'($urandom_range(0, 255));
            e  = {8'h00, av} * {8'h00, bv};
            accept(av, bv);
            wait_result((av == 8'h00 || bv == 8'h00) ? ZLAT : 4, "rand");
            take($urandom_range(0, 2), e, "rand");
        end

        repeat (2) @(negedge clk);
        check("hs_count", n_hs, n_take);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
